// File: rtl/i2c_reg_bridge_pkg.sv
// Shared types and sizing for the I2C slave register bridge.
// The state set is IDLE, PTR (expecting the pointer byte), WR (data writes) and RD (master reads).
package i2c_reg_bridge_pkg;

  localparam int NUM_REGS = 16;
  localparam int PTR_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/i2c_reg_bridge_edge_detect.sv
// Rising-edge detector for the slave's level-style handshake flags.
// The output is combinational, so an edge is acted on at the first clock edge that samples the flag high.
module i2c_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev <= 1'b0;
    else        r_prev <= in;
  end

  assign rise = in & ~r_prev;

endmodule

// File: rtl/i2c_reg_bridge.sv
// Bridges an I2C slave byte interface onto a 16x8 register file that a local host can also access.
// A START is followed by a pointer byte, then auto-incrementing writes; each consumed read byte advances the pointer.
module i2c_reg_bridge
  import i2c_reg_bridge_pkg::*;
#(
  parameter int REG_COUNT = NUM_REGS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             busstart,
  input  logic             busstop,
  input  logic [7:0]       datareceive,
  input  logic             received,
  input  logic             sended,
  output logic [7:0]       datasend,
  input  logic [PTR_W-1:0] hostaddr,
  input  logic [7:0]       hostwdata,
  input  logic             hostwe,
  output logic [7:0]       hostrdata,
  output logic             wrstrobe,
  output logic [PTR_W-1:0] wraddr,
  output logic             busy,
  output logic             collision
);

  bridge_state_t    r_state, w_state_next;
  logic [PTR_W-1:0] r_ptr, w_ptr_next;
  logic [7:0]       r_regs [REG_COUNT];
  logic             w_rx_rise, w_tx_rise;
  logic             w_i2c_we, w_host_we, w_collide;

  i2c_edge_detect u_rx_edge (.clk(clk), .reset(reset), .in(received), .rise(w_rx_rise));
  i2c_edge_detect u_tx_edge (.clk(clk), .reset(reset), .in(sended),   .rise(w_tx_rise));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // START overrides everything, including a byte arriving in the same cycle.
  // A coincident STOP still lets the byte be processed before closing.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_i2c_we     = 1'b0;
    if (busstart) begin
      w_state_next = ST_PTR;
    end else begin
      unique case (r_state)
        ST_PTR: begin
          if (w_rx_rise) begin
            w_ptr_next   = datareceive[PTR_W-1:0];
            w_state_next = ST_WR;
          end else if (w_tx_rise) begin
            w_ptr_next   = r_ptr + 4'd1;
            w_state_next = ST_RD;
          end
        end
        ST_WR: begin
          if (w_rx_rise) begin
            w_i2c_we   = 1'b1;
            w_ptr_next = r_ptr + 4'd1;
          end else if (w_tx_rise) begin
            w_ptr_next   = r_ptr + 4'd1;
            w_state_next = ST_RD;
          end
        end
        ST_RD: begin
          if (w_tx_rise) w_ptr_next = r_ptr + 4'd1;
        end
        default: ;
      endcase
      if (busstop) w_state_next = ST_IDLE;
    end
  end

  assign w_collide = hostwe & w_i2c_we & (hostaddr == r_ptr);
  assign w_host_we = hostwe & ~w_collide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= 8'h00;
    end else begin
      if (w_host_we) r_regs[hostaddr] <= hostwdata;
      if (w_i2c_we)  r_regs[r_ptr]    <= datareceive;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      datasend  <= 8'h00;
      wrstrobe  <= 1'b0;
      wraddr    <= '0;
      collision <= 1'b0;
    end else begin
      datasend  <= r_regs[r_ptr];
      wrstrobe  <= w_i2c_we;
      collision <= w_collide;
      if (w_i2c_we) wraddr <= r_ptr;
    end
  end

  assign hostrdata = r_regs[hostaddr];
  assign busy      = (r_state != ST_IDLE);

endmodule
